instruction_pointer_sequencer: RTL and testbench

Controller that owns every update of the instruction pointer register. It arbitrates between three sources and drives the register's write port: sequential advance from decode, branch redirect from execute, and trap/interrupt redirect from the exception unit. After each redirect it sequences a prefetch-flush window. It keeps a shadow copy of EIP so that back-to-back advances never read a stale register value.

---
 rtl/ip_seq_pkg.sv | 13 +
 rtl/ip_next_calc.sv | 46 ++++
 rtl/instruction_pointer_sequencer.sv | 162 ++++++++++++++++
 tb/tb_instruction_pointer_sequencer.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/ip_seq_pkg.sv
// Shared definitions for the instruction pointer sequencer and the IP register.
package ip_seq_pkg;

  localparam int unsigned IP_LEN_WIDTH = 4;
  localparam logic [31:0] IP_RESET_VALUE = 32'h0000_FFF0;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    FLUSH = 2'd1,
    FAULT = 2'd2
  } ip_seq_state_t;

endpackage

// File: rtl/ip_next_calc.sv
// Candidate next-IP values for advance, branch and trap in 16/32-bit mode.
// With IP_SEQ_LIMIT_CHECK_EN defined, the advance and branch candidates are
// also compared unsigned against the code-segment limit.
module ip_next_calc
  import ip_seq_pkg::*;
(
  input  logic                    operand_size_32,
  input  logic [31:0]             ip_cur,
  input  logic [IP_LEN_WIDTH-1:0] length,
  input  logic [31:0]             branch_target,
  input  logic [31:0]             trap_target,
  output logic [31:0]             advance_value,
  output logic [31:0]             branch_value,
  output logic [31:0]             trap_value
`ifdef IP_SEQ_LIMIT_CHECK_EN
  ,
  input  logic [31:0]             cs_limit,
  output logic                    advance_over,
  output logic                    branch_over
`endif
);

  logic [31:0] sum_32;
  logic [15:0] sum_16;

  // In 16-bit mode the offset wraps at 64K and the upper half is forced to zero.
  always_comb begin
    sum_32 = ip_cur + 32'(length);
    sum_16 = ip_cur[15:0] + 16'(length);
    if (operand_size_32) begin
      advance_value = sum_32;
      branch_value  = branch_target;
      trap_value    = trap_target;
    end else begin
      advance_value = {16'h0000, sum_16};
      branch_value  = {16'h0000, branch_target[15:0]};
      trap_value    = {16'h0000, trap_target[15:0]};
    end
  end

`ifdef IP_SEQ_LIMIT_CHECK_EN
  assign advance_over = (advance_value > cs_limit);
  assign branch_over  = (branch_value > cs_limit);
`endif

endmodule

// File: rtl/instruction_pointer_sequencer.sv
// Owns every write to the IP register: arbitrates trap > branch > advance,
// keeps a shadow copy of EIP and sequences the prefetch flush window.
// Optional code-segment limit checking is built when IP_SEQ_LIMIT_CHECK_EN
// is defined (adds cs_limit, limit_fault and the FAULT state).
//
// state | meaning
// RUN   | normal operation, advances and redirects accepted
// FLUSH | prefetch flush window after a redirect, only traps accepted
// FAULT | limit violation pending, only a trap leaves
module instruction_pointer_sequencer
  import ip_seq_pkg::*;
#(
  parameter int FLUSH_CYCLES = 2
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    operand_size_32,
  input  logic                    advance_valid,
  input  logic [IP_LEN_WIDTH-1:0] advance_length,
  input  logic                    branch_valid,
  input  logic [31:0]             branch_target,
  output logic                    branch_ready,
  input  logic                    trap_valid,
  input  logic [31:0]             trap_target,
  output logic                    trap_ready,
  output logic                    ip_write_enable,
  output logic [31:0]             ip_write_data,
  output logic                    flush
`ifdef IP_SEQ_LIMIT_CHECK_EN
  ,
  input  logic [31:0]             cs_limit,
  output logic                    limit_fault
`endif
);

  ip_seq_state_t state, state_next;
  logic [31:0]   ip_q, ip_next;
  logic          write_now;
  logic          load_count;
  logic [3:0]    flush_count;
  logic [31:0]   advance_value, branch_value, trap_value;
`ifdef IP_SEQ_LIMIT_CHECK_EN
  logic          advance_over, branch_over;
`endif

  ip_next_calc u_next_calc (
    .operand_size_32 (operand_size_32),
    .ip_cur          (ip_q),
    .length          (advance_length),
    .branch_target   (branch_target),
    .trap_target     (trap_target),
    .advance_value   (advance_value),
    .branch_value    (branch_value),
    .trap_value      (trap_value)
`ifdef IP_SEQ_LIMIT_CHECK_EN
    ,
    .cs_limit        (cs_limit),
    .advance_over    (advance_over),
    .branch_over     (branch_over)
`endif
  );

  // Next state, shadow update and handshake decode.
  always_comb begin
    state_next   = state;
    ip_next      = ip_q;
    write_now    = 1'b0;
    load_count   = 1'b0;
    branch_ready = 1'b1;
    trap_ready   = 1'b1;
    case (state)
      RUN: begin
        branch_ready = !trap_valid;
        if (trap_valid) begin
          ip_next    = trap_value;
          write_now  = 1'b1;
          load_count = 1'b1;
          state_next = FLUSH;
        end else if (branch_valid) begin
`ifdef IP_SEQ_LIMIT_CHECK_EN
          if (branch_over) state_next = FAULT;
          else
`endif
          begin
            ip_next    = branch_value;
            write_now  = 1'b1;
            load_count = 1'b1;
            state_next = FLUSH;
          end
        end else if (advance_valid && (advance_length != '0)) begin
`ifdef IP_SEQ_LIMIT_CHECK_EN
          if (advance_over) state_next = FAULT;
          else
`endif
          begin
            ip_next   = advance_value;
            write_now = 1'b1;
          end
        end
      end
      FLUSH: begin
        branch_ready = 1'b0;
        if (trap_valid) begin
          ip_next    = trap_value;
          write_now  = 1'b1;
          load_count = 1'b1;
        end else if (flush_count == 4'd1) begin
          state_next = RUN;
        end
      end
`ifdef IP_SEQ_LIMIT_CHECK_EN
      FAULT: begin
        branch_ready = 1'b0;
        if (trap_valid) begin
          ip_next    = trap_value;
          write_now  = 1'b1;
          load_count = 1'b1;
          state_next = FLUSH;
        end
      end
`endif
      default: state_next = RUN;
    endcase
  end

  // State, shadow IP and registered outputs.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state           <= RUN;
      ip_q            <= IP_RESET_VALUE;
      ip_write_enable <= 1'b0;
      ip_write_data   <= 32'h0000_0000;
      flush           <= 1'b0;
    end else begin
      state           <= state_next;
      ip_q            <= ip_next;
      ip_write_enable <= write_now;
      if (write_now) ip_write_data <= ip_next;
      flush           <= (state_next == FLUSH);
    end
  end

  // Flush window down-counter; the FSM leaves FLUSH on terminal count 1.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      flush_count <= 4'd0;
    end else if (load_count) begin
      flush_count <= 4'(FLUSH_CYCLES);
    end else if ((state == FLUSH) && (flush_count != 4'd0)) begin
      flush_count <= flush_count - 4'd1;
    end
  end

`ifdef IP_SEQ_LIMIT_CHECK_EN
  // limit_fault is high exactly while a violation is pending.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) limit_fault <= 1'b0;
    else       limit_fault <= (state_next == FAULT);
  end
`endif

endmodule

// File: tb/tb_instruction_pointer_sequencer.sv
// Scoreboard bench for instruction_pointer_sequencer; build with
// IP_SEQ_LIMIT_CHECK_EN defined to exercise the limit checking variant.
module tb_instruction_pointer_sequencer;

  localparam int FC = 2;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        operand_size_32 = 1'b1;
  logic        advance_valid = 1'b0;
  logic [3:0]  advance_length = 4'd0;
  logic        branch_valid = 1'b0;
  logic [31:0] branch_target = 32'h0;
  logic        branch_ready;
  logic        trap_valid = 1'b0;
  logic [31:0] trap_target = 32'h0;
  logic        trap_ready;
  logic        ip_write_enable;
  logic [31:0] ip_write_data;
  logic        flush;
`ifdef IP_SEQ_LIMIT_CHECK_EN
  logic [31:0] cs_limit = 32'hFFFF_FFFF;
  logic        limit_fault;
`endif

  instruction_pointer_sequencer #(.FLUSH_CYCLES(FC)) dut (
    .clock           (clock),
    .reset           (reset),
    .operand_size_32 (operand_size_32),
    .advance_valid   (advance_valid),
    .advance_length  (advance_length),
    .branch_valid    (branch_valid),
    .branch_target   (branch_target),
    .branch_ready    (branch_ready),
    .trap_valid      (trap_valid),
    .trap_target     (trap_target),
    .trap_ready      (trap_ready),
    .ip_write_enable (ip_write_enable),
    .ip_write_data   (ip_write_data),
    .flush           (flush)
`ifdef IP_SEQ_LIMIT_CHECK_EN
    ,
    .cs_limit        (cs_limit),
    .limit_fault     (limit_fault)
`endif
  );

  always #5 clock = ~clock;

  int errors = 0;
  int checks = 0;
  logic [31:0] exp_q[$];

  // Reference model: current IP, remaining flush cycles, pending fault.
  logic [31:0] m_ip = 32'h0000_FFF0;
  int          m_flush_left = 0;
  bit          m_fault = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every write pulse must match the oldest expected write.
  always @(negedge clock) begin
    if (!reset && ip_write_enable) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL write_unexpected: got %h expected none", ip_write_data);
      end else begin
        logic [31:0] e;
        e = exp_q.pop_front();
        if (ip_write_data !== e) begin
          errors++;
          $display("FAIL write_data: got %h expected %h", ip_write_data, e);
        end
      end
    end
  end

  function automatic logic [31:0] fit(input logic [31:0] v);
    return operand_size_32 ? v : {16'h0000, v[15:0]};
  endfunction

  function automatic bit over_limit(input logic [31:0] v);
`ifdef IP_SEQ_LIMIT_CHECK_EN
    return v > cs_limit;
`else
    return (v != v);
`endif
  endfunction

  task automatic model_redirect(input logic [31:0] v);
    m_ip = v;
    exp_q.push_back(v);
    m_flush_left = FC;
  endtask

  // Apply one cycle of requests, check handshake, advance model and DUT.
  task automatic step(input bit tv, input logic [31:0] tt, input bit bv,
                      input logic [31:0] bt, input bit av, input logic [3:0] al);
    logic [31:0] cand;
    trap_valid = tv; trap_target = tt;
    branch_valid = bv; branch_target = bt;
    advance_valid = av; advance_length = al;
    #1;
    chk("trap_ready", {31'b0, trap_ready}, 32'd1);
    chk("branch_ready", {31'b0, branch_ready},
        (m_flush_left == 0 && !m_fault) ? {31'b0, !tv} : 32'd0);
    if (tv) begin
      model_redirect(fit(tt));
      m_fault = 1'b0;
    end else if (m_flush_left > 0) begin
      m_flush_left--;
    end else if (m_fault) begin
      // only a trap leaves a pending fault
    end else if (bv) begin
      cand = fit(bt);
      if (over_limit(cand)) m_fault = 1'b1;
      else model_redirect(cand);
    end else if (av && al != 4'd0) begin
      cand = operand_size_32 ? m_ip + 32'(al) : {16'h0000, m_ip[15:0] + 16'(al)};
      if (over_limit(cand)) m_fault = 1'b1;
      else begin
        m_ip = cand;
        exp_q.push_back(cand);
      end
    end
    @(posedge clock);
    #1;
    chk("flush", {31'b0, flush}, {31'b0, m_flush_left > 0});
`ifdef IP_SEQ_LIMIT_CHECK_EN
    chk("limit_fault", {31'b0, limit_fault}, {31'b0, m_fault});
`endif
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0);
  endtask

  // Assert reset between edges; outputs must drop at once.
  task automatic do_reset();
    reset = 1'b1;
    #1;
    chk("rst_flush", {31'b0, flush}, 32'd0);
    chk("rst_write_enable", {31'b0, ip_write_enable}, 32'd0);
    exp_q.delete();
    m_ip = 32'h0000_FFF0;
    m_flush_left = 0;
    m_fault = 1'b0;
    @(posedge clock);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    repeat (2) @(posedge clock);
    #1;
    chk("reset_write_data", ip_write_data, 32'h0);
    chk("reset_write_enable", {31'b0, ip_write_enable}, 32'd0);
    chk("reset_flush", {31'b0, flush}, 32'd0);
    chk("reset_branch_ready", {31'b0, branch_ready}, 32'd1);
    chk("reset_trap_ready", {31'b0, trap_ready}, 32'd1);
    reset = 1'b0;

    // Back-to-back advances from reset: FFF3 then FFF5.
    step(0, 0, 0, 0, 1, 4'd3);
    step(0, 0, 0, 0, 1, 4'd2);
    chk("ip_after_advances", m_ip, 32'h0000_FFF5);
    idle(1);

    // 16-bit wrap: FFF5 + 9 = FFFE, then + 4 wraps to 0002.
    operand_size_32 = 1'b0;
    step(0, 0, 0, 0, 1, 4'd9);
    step(0, 0, 0, 0, 1, 4'd4);
    chk("ip_16bit_wrap", m_ip, 32'h0000_0002);
    operand_size_32 = 1'b1;

    // Trap, branch and advance together: trap wins.
    step(1, 32'h0000_1000, 1, 32'h0000_2000, 1, 4'd5);
    step(0, 0, 1, 32'h0000_2000, 1, 4'd1);
    step(0, 0, 1, 32'h0000_2000, 1, 4'd1);
    step(0, 0, 1, 32'h0000_2000, 0, 4'd0);
    idle(3);

    // Reset during the first flush cycle; then advance 1 from FFF0.
    step(0, 0, 1, 32'h0000_3000, 0, 4'd0);
    do_reset();
    step(0, 0, 0, 0, 1, 4'd1);
    chk("ip_after_reset", m_ip, 32'h0000_FFF1);
    idle(1);

`ifdef IP_SEQ_LIMIT_CHECK_EN
    do_reset();
    cs_limit = 32'h0000_FFF4;
    step(0, 0, 0, 0, 1, 4'd3);
    step(0, 0, 0, 0, 1, 4'd2);
    chk("fault_ip_kept", m_ip, 32'h0000_FFF3);
    step(0, 0, 0, 0, 1, 4'd1);
    step(0, 0, 1, 32'h0000_0010, 0, 4'd0);
    step(1, 32'h0000_0000, 0, 0, 1, 4'd1);
    idle(3);
`endif

    // Randomized traffic.
    for (int i = 0; i < 600; i++) begin
      if (i % 50 == 0) begin
        operand_size_32 = 1'($urandom_range(0, 1));
`ifdef IP_SEQ_LIMIT_CHECK_EN
        cs_limit = ($urandom_range(0, 1) == 1) ? $urandom : 32'($urandom_range(0, 32'h0001_FFFF));
`endif
      end
      step($urandom_range(0, 9) == 0,
           ($urandom_range(0, 1) == 1) ? $urandom : 32'($urandom_range(0, 32'h0000_FFFF)),
           $urandom_range(0, 4) == 0,
           ($urandom_range(0, 1) == 1) ? $urandom : 32'($urandom_range(0, 32'h0000_FFFF)),
           $urandom_range(0, 1) == 1,
           4'($urandom_range(0, 15)));
      if (i == 300) do_reset();
    end

    idle(4);
    chk("pending_writes", exp_q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
